vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

Timing generator at the transmit end of the VGA link: generates the HSync/VSync pair that `sync_to_count` consumes, with real porches and sync pulses. It exposes the raster position so game logic can compute a pixel, then registers and blanks that pixel so video and sync leave the block on the same edge. It sits between the pixel-producing game logic and the board VGA pins, and also provides a per-frame tick for animation timing.

## Interface
- TOTAL_COLS, 800, pixel clocks per line
- TOTAL_ROWS, 525, lines per frame
- ACTIVE_COLS, 640, visible pixels per line
- ACTIVE_ROWS, 480, visible lines per frame
- H_FRONT_PORCH, 16, clocks between the end of active video and the start of HSync
- H_SYNC_PULSE, 96, HSync width in clocks
- V_FRONT_PORCH, 10, lines between the end of active video and the start of VSync
- V_SYNC_PULSE, 2, VSync width in lines
- SYNC_ACTIVE_LOW, 1, 1 = sync pulses drive 0, 0 = sync pulses drive 1

Ports:
- i_Clk  in  1  pixel clock (25 MHz)
- i_Reset  in  1  asynchronous, active-high reset
- i_Red_Video / i_Grn_Video / i_Blu_Video  in  4 each  pixel colour for the current o_Col_Count/o_Row_Count; combinational from the counts
- o_Col_Count  out  10  current column, 0..TOTAL_COLS-1
- o_Row_Count  out  10  current row, 0..TOTAL_ROWS-1
- o_HSync / o_VSync  out  1 each  sync outputs, polarity set by SYNC_ACTIVE_LOW
- o_Active  out  1  high when the registered video output is in the visible area
- o_Red_Video / o_Grn_Video / o_Blu_Video  out  4 each  registered, blanked colour
- o_Frame_Start  out  1  one-cycle pulse aligned with output pixel (0,0)
- o_Frame_Count  out  8  completed-frame counter

## Operation
- Column counter:
  - increments every clock;
  - at TOTAL_COLS-1 it wraps to 0 and the row counter increments.
- Row counter wraps from TOTAL_ROWS-1 to 0 on the same edge that the column counter wraps.
- o_Col_Count and o_Row_Count are the counter registers themselves.
- Visible region: col < ACTIVE_COLS and row < ACTIVE_ROWS.
- HSync asserted when col is in [ACTIVE_COLS+H_FRONT_PORCH, ACTIVE_COLS+H_FRONT_PORCH+H_SYNC_PULSE). Defaults: cols 656..751.
- VSync asserted when row is in [ACTIVE_ROWS+V_FRONT_PORCH, ACTIVE_ROWS+V_FRONT_PORCH+V_SYNC_PULSE). Defaults: rows 490..491. VSync is asserted for whole lines, not qualified by column.
- Asserted level is 0 when SYNC_ACTIVE_LOW=1, else 1. The deasserted level is the complement.
- Output video:
  - = input colour when the sampled position is visible;
  - = 4'h0 on all channels otherwise, regardless of the input.
- o_Frame_Start = 1 for exactly the output cycle corresponding to position (0,0).
- o_Frame_Count increments by 1 on the edge where the counters wrap (TOTAL_COLS-1, TOTAL_ROWS-1) -> (0,0). It wraps 255 -> 0.
- Parameter legality: porch plus sync must be no larger than the blanking interval, and all counts must fit in 10 bits. Violations are caught by elaboration-time checks that stop simulation.

## Timing
- Reset asserted, asynchronously:
  - counts = 0, o_Frame_Count = 0;
  - o_HSync / o_VSync = deasserted level (1 for defaults);
  - o_Active = 0, video = 0, o_Frame_Start = 0.
- Latency is 1 clock from counts to outputs. On each edge, the block registers sync, active flag, blanked colour and frame-start for the count values present before that edge. All five outputs are therefore mutually aligned, and lag o_Col_Count/o_Row_Count by 1 cycle.
- First edge after reset release:
  - counters -> (1,0);
  - registered outputs reflect (0,0), so o_Frame_Start = 1 and o_Active = 1;
  - o_Frame_Count stays 0 until the first full frame completes.
- HSync period is TOTAL_COLS clocks; VSync period is TOTAL_COLS*TOTAL_ROWS clocks (420000 for defaults).
- Reset mid-frame: all outputs return to their reset values immediately. On release, a fresh frame starts at (0,0) with no partial-frame increment of o_Frame_Count.
- i_*_Video is sampled only at clock edges. Glitches between edges have no effect.

## Test plan
- Reset/release: hold i_Reset 5 cycles, then release. Required:
  - outputs held at their reset values during reset;
  - on the first edge after release, counts = (1,0), o_Frame_Start = 1, o_HSync = o_VSync = 1.
- Horizontal timing with defaults: measure o_HSync. Required: low for exactly 96 clocks, first low on the output cycle for col 656, period 800 clocks.
- Vertical timing: measure o_VSync. Required: low for exactly 1600 clocks, starting at the output cycle for row 490 col 0, period 420000 clocks.
- Blanking: drive i_Red/Grn/Blu = 4'hF constantly. Required:
  - output video = 4'hF on 640 clocks per visible line, 0 on the other 160;
  - all-zero throughout rows 480..524;
  - o_Active mirrors exactly the non-zero cycles.
- Frame counter: run 257 frames. Required:
  - o_Frame_Start pulses 257 times, each 1 cycle wide;
  - o_Frame_Count steps 0 -> 255 -> 0 -> 1 at each (524,799) -> (0,0) wrap.
- Mid-frame reset and loopback:
  - Assert i_Reset at row 200 col 300. Required: immediate reset values, restart at (0,0) after release, o_Frame_Count = 0.
  - Feed o_HSync/o_VSync into sync_to_count. Required: its recovered counts match this block's counts, delayed by its fixed pipeline latency.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: free-running column/row counters, sync pulses with porches,
// and a one-clock output stage that blanks caller-supplied colour so video and sync stay aligned.
module vga_sync_gen #(
    parameter int TOTAL_COLS      = 800,
    parameter int TOTAL_ROWS      = 525,
    parameter int ACTIVE_COLS     = 640,
    parameter int ACTIVE_ROWS     = 480,
    parameter int H_FRONT_PORCH   = 16,
    parameter int H_SYNC_PULSE    = 96,
    parameter int V_FRONT_PORCH   = 10,
    parameter int V_SYNC_PULSE    = 2,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [3:0] i_Red_Video,
    input  logic [3:0] i_Grn_Video,
    input  logic [3:0] i_Blu_Video,
    output logic [9:0] o_Col_Count,
    output logic [9:0] o_Row_Count,
    output logic       o_HSync,
    output logic       o_VSync,
    output logic       o_Active,
    output logic [3:0] o_Red_Video,
    output logic [3:0] o_Grn_Video,
    output logic [3:0] o_Blu_Video,
    output logic       o_Frame_Start,
    output logic [7:0] o_Frame_Count
);

    if (TOTAL_COLS < 1 || TOTAL_COLS > 1024 || TOTAL_ROWS < 1 || TOTAL_ROWS > 1024) begin : g_bad_total
        $fatal(1, "vga_sync_gen: TOTAL_COLS/TOTAL_ROWS must be 1..1024");
    end
    if (ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_PULSE > TOTAL_COLS) begin : g_bad_h
        $fatal(1, "vga_sync_gen: horizontal porch + sync exceed blanking interval");
    end
    if (ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_PULSE > TOTAL_ROWS) begin : g_bad_v
        $fatal(1, "vga_sync_gen: vertical porch + sync exceed blanking interval");
    end

    // 11-bit boundaries so a sync pulse ending exactly at 1024 still compares correctly
    localparam logic [10:0] COL_LAST = 11'(TOTAL_COLS - 1);
    localparam logic [10:0] ROW_LAST = 11'(TOTAL_ROWS - 1);
    localparam logic [10:0] ACT_COLS = 11'(ACTIVE_COLS);
    localparam logic [10:0] ACT_ROWS = 11'(ACTIVE_ROWS);
    localparam logic [10:0] HS_START = 11'(ACTIVE_COLS + H_FRONT_PORCH);
    localparam logic [10:0] HS_END   = 11'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_PULSE);
    localparam logic [10:0] VS_START = 11'(ACTIVE_ROWS + V_FRONT_PORCH);
    localparam logic [10:0] VS_END   = 11'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_PULSE);
    localparam logic        SYNC_OFF = SYNC_ACTIVE_LOW;
    localparam logic        SYNC_ON  = !SYNC_ACTIVE_LOW;

    function automatic logic sync_level(input logic on);
        return on ? SYNC_ON : SYNC_OFF;
    endfunction

    function automatic logic [3:0] blank_pixel(input logic [3:0] colour, input logic visible);
        return visible ? colour : 4'h0;
    endfunction

    logic [10:0] col_ext;
    logic [10:0] row_ext;
    logic        col_wrap;
    logic        row_wrap;
    logic        visible;
    logic        hs_on;
    logic        vs_on;
    logic        at_origin;

    always_comb begin
        col_ext   = {1'b0, o_Col_Count};
        row_ext   = {1'b0, o_Row_Count};
        col_wrap  = (col_ext == COL_LAST);
        row_wrap  = (row_ext == ROW_LAST);
        visible   = (col_ext < ACT_COLS) && (row_ext < ACT_ROWS);
        hs_on     = (col_ext >= HS_START) && (col_ext < HS_END);
        vs_on     = (row_ext >= VS_START) && (row_ext < VS_END);
        at_origin = (o_Col_Count == 10'd0) && (o_Row_Count == 10'd0);
    end

    // Stage p0: raster counters and completed-frame counter
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            o_Col_Count   <= 10'd0;
            o_Row_Count   <= 10'd0;
            o_Frame_Count <= 8'd0;
        end else if (col_wrap) begin
            o_Col_Count <= 10'd0;
            if (row_wrap) begin
                o_Row_Count   <= 10'd0;
                o_Frame_Count <= o_Frame_Count + 8'd1;
            end else begin
                o_Row_Count <= o_Row_Count + 10'd1;
            end
        end else begin
            o_Col_Count <= o_Col_Count + 10'd1;
        end
    end

    logic       hsync_p1;
    logic       vsync_p1;
    logic       vld_p1;
    logic       frame_start_p1;
    logic [3:0] red_p1;
    logic [3:0] grn_p1;
    logic [3:0] blu_p1;

    // Stage p1: everything describing the pre-edge position, registered together
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            hsync_p1       <= SYNC_OFF;
            vsync_p1       <= SYNC_OFF;
            vld_p1         <= 1'b0;
            frame_start_p1 <= 1'b0;
            red_p1         <= 4'h0;
            grn_p1         <= 4'h0;
            blu_p1         <= 4'h0;
        end else begin
            hsync_p1       <= sync_level(hs_on);
            vsync_p1       <= sync_level(vs_on);
            vld_p1         <= visible;
            frame_start_p1 <= at_origin;
            red_p1         <= blank_pixel(i_Red_Video, visible);
            grn_p1         <= blank_pixel(i_Grn_Video, visible);
            blu_p1         <= blank_pixel(i_Blu_Video, visible);
        end
    end

    assign o_HSync       = hsync_p1;
    assign o_VSync       = vsync_p1;
    assign o_Active      = vld_p1;
    assign o_Frame_Start = frame_start_p1;
    assign o_Red_Video   = red_p1;
    assign o_Grn_Video   = grn_p1;
    assign o_Blu_Video   = blu_p1;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen on a shrunken raster so hundreds of frames fit in a short run;
// a linear-position reference model is compared against the DUT every cycle.
module tb_vga_sync_gen;

    localparam int TC  = 16;
    localparam int TR  = 10;
    localparam int AC  = 10;
    localparam int AR  = 6;
    localparam int HFP = 2;
    localparam int HS  = 3;
    localparam int VFP = 1;
    localparam int VS  = 2;
    localparam int F   = TC * TR;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] r_in = 4'h0, g_in = 4'h0, b_in = 4'h0;
    logic [9:0] col_cnt, row_cnt;
    logic       hsync, vsync, active, fstart;
    logic [3:0] r_out, g_out, b_out;
    logic [7:0] fcount;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vga_sync_gen #(
        .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
        .H_FRONT_PORCH(HFP), .H_SYNC_PULSE(HS), .V_FRONT_PORCH(VFP), .V_SYNC_PULSE(VS),
        .SYNC_ACTIVE_LOW(1'b1)
    ) dut (
        .i_Clk(clk), .i_Reset(rst),
        .i_Red_Video(r_in), .i_Grn_Video(g_in), .i_Blu_Video(b_in),
        .o_Col_Count(col_cnt), .o_Row_Count(row_cnt),
        .o_HSync(hsync), .o_VSync(vsync), .o_Active(active),
        .o_Red_Video(r_out), .o_Grn_Video(g_out), .o_Blu_Video(b_out),
        .o_Frame_Start(fstart), .o_Frame_Count(fcount)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: raster is a single linear position; outputs describe the position held before the last edge
    int         m_pos = 0;
    int         m_fc  = 0;
    bit         m_vld = 1'b0;
    int         m_op  = 0;
    logic [3:0] m_r = 4'h0, m_g = 4'h0, m_b = 4'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pos <= 0;
            m_fc  <= 0;
            m_vld <= 1'b0;
            m_op  <= 0;
            m_r   <= 4'h0;
            m_g   <= 4'h0;
            m_b   <= 4'h0;
        end else begin
            m_vld <= 1'b1;
            m_op  <= m_pos;
            m_r   <= r_in;
            m_g   <= g_in;
            m_b   <= b_in;
            m_pos <= (m_pos + 1) % F;
            if (m_pos == F - 1) m_fc <= (m_fc + 1) % 256;
        end
    end

    int cyc = 0;
    int hs_fall = -1, vs_fall = -1;
    bit hs_prev = 1'b1, vs_prev = 1'b1;
    int act_cnt = 0;
    bit act_vld = 1'b0;
    int fs_seen = 0;

    always @(negedge clk) begin
        int c, r, e_hs, e_vs, e_act, e_fs;
        int e_r, e_g, e_b;
        bit vis;
        cyc++;
        c     = m_op % TC;
        r     = m_op / TC;
        vis   = (c < AC) && (r < AR);
        e_hs  = (m_vld && c >= AC + HFP && c < AC + HFP + HS) ? 0 : 1;
        e_vs  = (m_vld && r >= AR + VFP && r < AR + VFP + VS) ? 0 : 1;
        e_act = (m_vld && vis) ? 1 : 0;
        e_fs  = (m_vld && m_op == 0) ? 1 : 0;
        e_r   = (m_vld && vis) ? int'(m_r) : 0;
        e_g   = (m_vld && vis) ? int'(m_g) : 0;
        e_b   = (m_vld && vis) ? int'(m_b) : 0;
        chk("col_count", int'(col_cnt), m_pos % TC);
        chk("row_count", int'(row_cnt), m_pos / TC);
        chk("hsync", int'(hsync), e_hs);
        chk("vsync", int'(vsync), e_vs);
        chk("active", int'(active), e_act);
        chk("frame_start", int'(fstart), e_fs);
        chk("frame_count", int'(fcount), m_fc);
        chk("red", int'(r_out), e_r);
        chk("grn", int'(g_out), e_g);
        chk("blu", int'(b_out), e_b);
        if (m_vld && m_r == 4'hF && m_g == 4'hF && m_b == 4'hF)
            chk("active_vs_video", int'(active), (r_out != 4'h0) ? 1 : 0);

        if (rst) begin
            hs_fall = -1;  vs_fall = -1;
            hs_prev = 1'b1; vs_prev = 1'b1;
            act_vld = 1'b0; act_cnt = 0;
            fs_seen = 0;
        end else begin
            if (hs_prev && !hsync) begin
                chk("hs_start_col", int'(col_cnt), AC + HFP + 1);
                if (hs_fall >= 0) chk("hs_period", cyc - hs_fall, TC);
                hs_fall = cyc;
            end
            if (!hs_prev && hsync && hs_fall >= 0) chk("hs_width", cyc - hs_fall, HS);
            if (vs_prev && !vsync) begin
                chk("vs_start_pos", int'(row_cnt) * TC + int'(col_cnt), (AR + VFP) * TC + 1);
                if (vs_fall >= 0) chk("vs_period", cyc - vs_fall, F);
                vs_fall = cyc;
            end
            if (!vs_prev && vsync && vs_fall >= 0) chk("vs_width", cyc - vs_fall, VS * TC);
            hs_prev = hsync;
            vs_prev = vsync;
            if (fstart) begin
                fs_seen++;
                if (act_vld) chk("active_per_frame", act_cnt, AC * AR);
                act_vld = 1'b1;
                act_cnt = int'(active);
            end else begin
                act_cnt += int'(active);
            end
        end
    end

    task automatic drive_colour(input bit all_f);
        if (all_f) begin
            r_in = 4'hF; g_in = 4'hF; b_in = 4'hF;
        end else begin
            r_in = 4'($urandom_range(0, 15));
            g_in = 4'($urandom_range(0, 15));
            b_in = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic check_reset_literals(input string tag);
        chk({tag, "_col"}, int'(col_cnt), 0);
        chk({tag, "_row"}, int'(row_cnt), 0);
        chk({tag, "_hsync"}, int'(hsync), 1);
        chk({tag, "_vsync"}, int'(vsync), 1);
        chk({tag, "_active"}, int'(active), 0);
        chk({tag, "_video"}, int'({r_out, g_out, b_out}), 0);
        chk({tag, "_fstart"}, int'(fstart), 0);
        chk({tag, "_fcount"}, int'(fcount), 0);
    endtask

    task automatic check_first_edge(input string tag);
        chk({tag, "_col"}, int'(col_cnt), 1);
        chk({tag, "_row"}, int'(row_cnt), 0);
        chk({tag, "_fstart"}, int'(fstart), 1);
        chk({tag, "_active"}, int'(active), 1);
        chk({tag, "_hsync"}, int'(hsync), 1);
        chk({tag, "_vsync"}, int'(vsync), 1);
        chk({tag, "_fcount"}, int'(fcount), 0);
    endtask

    initial begin
        int  fs_before;
        bit  found;
        drive_colour(1'b0);
        repeat (5) @(negedge clk);
        #1 check_reset_literals("in_reset");

        @(negedge clk);
        rst = 1'b0;
        drive_colour(1'b0);
        @(posedge clk);
        #1 check_first_edge("release");

        // 257 frames: random colour except two all-white frames for the blanking checks
        for (int e = 2; e <= 257 * F; e++) begin
            @(negedge clk);
            #1 drive_colour(((e - 1) / F == 3) || ((e - 1) / F == 4));
        end
        fs_before = fs_seen;
        @(posedge clk);
        #1;
        chk("frame_pulses_257", fs_before, 257);
        chk("fcount_after_257", int'(fcount), 1);
        chk("wrap_col", int'(col_cnt), 0);
        chk("wrap_row", int'(row_cnt), 0);

        found = 1'b0;
        for (int i = 0; i < 2 * F && !found; i++) begin
            @(negedge clk);
            if (row_cnt == 10'd3 && col_cnt == 10'd7) found = 1'b1;
            else drive_colour(1'b0);
        end
        chk("midframe_reached", int'(found), 1);
        #2 rst = 1'b1;
        #1 check_reset_literals("midframe_reset");
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1 check_first_edge("restart");

        for (int e = 0; e < F + 8; e++) begin
            @(negedge clk);
            #1 drive_colour(1'b0);
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
